// File: rtl/pio_pattern_sequencer.sv
// Replays a CPU-programmed table of LED patterns into the PIO at a programmable step period.
// Optional done interrupt (irq port, CTRL.IE) is built only when PIO_SEQ_IRQ_EN is defined.
module pio_pattern_sequencer #(
    parameter int DATA_WIDTH   = 6,
    parameter int DEPTH        = 8,
    parameter int PERIOD_WIDTH = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
`ifdef PIO_SEQ_IRQ_EN
    output logic        irq,
`endif
    output logic [31:0] m_writedata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]              state_q, state_d;
    logic                    run_q, run_d;
    logic                    loop_q, loop_d;
    logic                    ie_q, ie_d;
    logic                    done_q, done_d;
    logic                    irq_q, irq_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   pat_q, pat_d;
    logic [DATA_WIDTH-1:0]   tbl_q [DEPTH];
    logic [DATA_WIDTH-1:0]   tbl_d [DEPTH];

    logic wr, wr_ctrl, wr_status, start, stop;
    logic unused_wdata;

    assign wr        = s_chipselect & ~s_write_n;
    assign wr_ctrl   = wr && (s_address == 4'd0);
    assign wr_status = wr && (s_address == 4'd3);
    // Only a RUN 0->1 edge starts a run; RUN=1 while running just rewrites LOOP.
    assign start     = wr_ctrl & s_writedata[0] & ~run_q;
    assign stop      = wr_ctrl & ~s_writedata[0];
    assign unused_wdata = ^s_writedata;

    // NOTE: every _d gets its current value first so no path through this block infers a latch.
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        loop_d   = loop_q;
        ie_d     = ie_q;
        done_d   = done_q;
        period_d = period_q;
        last_d   = last_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        pat_d    = pat_q;
        tbl_d    = tbl_q;
        irq_d    = done_q & ie_q;

        if (wr_ctrl) begin
            run_d  = s_writedata[0];
            loop_d = s_writedata[1];
`ifdef PIO_SEQ_IRQ_EN
            ie_d   = s_writedata[2];
`endif
        end
        if (wr && s_address == 4'd1) period_d = s_writedata[PERIOD_WIDTH-1:0];
        if (wr && s_address == 4'd2) last_d   = s_writedata[IDX_W-1:0];
        if (wr_status && s_writedata[1]) done_d = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr && i < 8 && s_address[3] && s_address[2:0] == 3'(i))
                tbl_d[i] = s_writedata[DATA_WIDTH-1:0];
        end

        if (state_q == ST_WRITE) pat_d = tbl_q[idx_q];

        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_WRITE;
                        idx_d   = '0;
                        done_d  = 1'b0;
                    end
                end
                ST_WRITE: begin
                    cnt_d   = (period_q < PERIOD_WIDTH'(2)) ? '0 : period_q - PERIOD_WIDTH'(2);
                    state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - PERIOD_WIDTH'(1);
                    end else if (idx_q != last_q) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_WRITE;
                    end else if (loop_q) begin
                        idx_d   = '0;
                        state_d = ST_WRITE;
                    end else begin
                        run_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            run_q    <= 1'b0;
            loop_q   <= 1'b0;
            ie_q     <= 1'b0;
            done_q   <= 1'b0;
            irq_q    <= 1'b0;
            period_q <= '0;
            last_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            pat_q    <= '0;
            // NOTE: the pattern table is reset because software expects it to read back as zero.
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            loop_q   <= loop_d;
            ie_q     <= ie_d;
            done_q   <= done_d;
            irq_q    <= irq_d;
            period_q <= period_d;
            last_q   <= last_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            pat_q    <= pat_d;
            tbl_q    <= tbl_d;
        end
    end

    always_comb begin
        s_readdata = '0;
        case (s_address)
            4'd0: s_readdata = {29'd0, ie_q, loop_q, run_q};
            4'd1: s_readdata = 32'(period_q);
            4'd2: s_readdata = 32'(last_q);
            4'd3: s_readdata = {24'd0, 4'(idx_q), 2'b00, done_q, state_q != ST_IDLE};
            default: begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (i < 8 && s_address[3] && s_address[2:0] == 3'(i))
                        s_readdata = 32'(tbl_q[i]);
                end
            end
        endcase
    end

    // The PIO sees the live table entry during WRITE and the latched pattern afterwards.
    assign m_address    = 2'b00;
    assign m_chipselect = (state_q == ST_WRITE);
    assign m_write_n    = ~m_chipselect;
    assign m_writedata  = 32'(m_chipselect ? tbl_q[idx_q] : pat_q);
`ifdef PIO_SEQ_IRQ_EN
    assign irq = irq_q;
`else
    logic unused_irq;
    assign unused_irq = irq_q;
`endif

endmodule

// File: tb/tb_pio_pattern_sequencer.sv
// Self-checking bench for pio_pattern_sequencer: register vectors, directed run sequences,
// and randomized runs compared against an arithmetic schedule of expected PIO writes.
module tb_pio_pattern_sequencer;

    localparam int DW    = 6;
    localparam int DEPTH = 8;
    localparam int PW    = 24;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  s_address;
    logic        s_chipselect;
    logic        s_write_n;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
`ifdef PIO_SEQ_IRQ_EN
    logic        irq;
`endif

    pio_pattern_sequencer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PERIOD_WIDTH(PW)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_address    (s_address),
        .s_chipselect (s_chipselect),
        .s_write_n    (s_write_n),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
`ifdef PIO_SEQ_IRQ_EN
        .irq          (irq),
`endif
        .m_writedata  (m_writedata)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int last_wr_cyc;

    logic [31:0] wq_data[$];
    int          wq_cyc[$];
    logic [DW-1:0] exp_tbl [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every PIO write strobe together with the cycle it was seen in.
    always @(negedge clk) begin
        if (m_chipselect && !m_write_n) begin
            wq_data.push_back(m_writedata);
            wq_cyc.push_back(cyc);
        end
    end

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        s_address    = addr;
        s_writedata  = data;
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        last_wr_cyc  = cyc;
        @(negedge clk);
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
        s_address = addr;
        #1;
        data = s_readdata;
    endtask

    task automatic wait_idle(input int budget, input string name);
        logic [31:0] st;
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            bus_read(4'd3, st);
            if (!st[0]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, " reached idle"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        for (int i = 0; i < budget && wq_data.size() < n; i++) @(negedge clk);
        check({name, " write count reached"}, 32'(wq_data.size() >= n), 32'd1);
    endtask

    task automatic load_table();
        for (int i = 0; i < DEPTH; i++) bus_write(4'(8 + i), 32'(exp_tbl[i]));
    endtask

    // One non-looping run: the expected schedule is entries 0..last, step max(period,2),
    // the first one cycle after the RUN write, then DONE with the index parked at last.
    task automatic run_once(input int last, input int period, input string tag);
        int sp, start;
        logic [31:0] rd;
        sp = (period < 2) ? 2 : period;
        bus_write(4'd2, 32'(last));
        bus_write(4'd1, 32'(period));
        wq_data.delete();
        wq_cyc.delete();
        bus_write(4'd0, 32'h1);
        start = last_wr_cyc;
        wait_idle((last + 1) * sp + 20, tag);
        check({tag, " write count"}, 32'(wq_data.size()), 32'(last + 1));
        for (int k = 0; k <= last && k < wq_data.size(); k++) begin
            check($sformatf("%s data[%0d]", tag, k), wq_data[k], 32'(exp_tbl[k]));
            check($sformatf("%s cycle[%0d]", tag, k), 32'(wq_cyc[k]), 32'(start + 1 + k * sp));
        end
        bus_read(4'd3, rd);
        check({tag, " status"}, rd, 32'h2 | 32'(last << 4));
        bus_read(4'd0, rd);
        check({tag, " ctrl run cleared"}, rd, 32'h0);
        bus_write(4'd3, 32'h2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int n, start;

        reset        = 1'b1;
        s_address    = '0;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
        s_writedata  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        for (int a = 0; a < 16; a++) begin
            bus_read(4'(a), rd);
            check($sformatf("reset read addr %0d", a), rd, 32'h0);
        end
        check("reset m_chipselect", 32'(m_chipselect), 32'd0);
        check("reset m_write_n", 32'(m_write_n), 32'd1);
        check("reset m_writedata", m_writedata, 32'h0);
        check("m_address", 32'(m_address), 32'h0);

        // Register write/readback vectors
        vecs[0] = '{4'd1,  32'hFFFF_FFFF, 32'h00FF_FFFF};
        vecs[1] = '{4'd1,  32'h0000_000A, 32'h0000_000A};
        vecs[2] = '{4'd2,  32'hFFFF_FFFF, 32'h0000_0007};
        vecs[3] = '{4'd2,  32'h0000_0003, 32'h0000_0003};
        vecs[4] = '{4'd8,  32'hFFFF_FFFF, 32'h0000_003F};
        vecs[5] = '{4'd15, 32'h0000_0015, 32'h0000_0015};
        vecs[6] = '{4'd4,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[7] = '{4'd7,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[8] = '{4'd3,  32'hFFFF_FFFF, 32'h0000_0000};
`ifdef PIO_SEQ_IRQ_EN
        vecs[9] = '{4'd0,  32'h0000_0006, 32'h0000_0006};
`else
        vecs[9] = '{4'd0,  32'h0000_0006, 32'h0000_0002};
`endif
        for (int i = 0; i < 10; i++) begin
            bus_write(vecs[i].addr, vecs[i].wdata);
            bus_read(vecs[i].addr, rd);
            check($sformatf("vector %0d addr %0d", i, vecs[i].addr), rd, vecs[i].exp);
        end
        bus_write(4'd0, 32'h0);

        // Basic four-step run, PERIOD=10
        exp_tbl = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h3F, 6'h2A};
        load_table();
        run_once(3, 10, "basic");

        // Looping at the minimum spacing, then LOOP dropped by a RUN=1 rewrite
        bus_write(4'd2, 32'd3);
        bus_write(4'd1, 32'd0);
        wq_data.delete();
        wq_cyc.delete();
        bus_write(4'd0, 32'h3);
        start = last_wr_cyc;
        repeat (20) @(negedge clk);
        bus_read(4'd3, rd);
        check("loop busy no done", rd & 32'h3, 32'h1);
        bus_write(4'd0, 32'h1);
        wait_idle(40, "loop end");
        check("loop write count", 32'(wq_data.size() >= 10), 32'd1);
        for (int k = 0; k < wq_data.size(); k++) begin
            check($sformatf("loop data[%0d]", k), wq_data[k], 32'(exp_tbl[k % 4]));
            check($sformatf("loop cycle[%0d]", k), 32'(wq_cyc[k]), 32'(start + 1 + 2 * k));
        end
        check("loop last pattern", wq_data[wq_data.size() - 1], 32'h08);
        bus_read(4'd3, rd);
        check("loop end status", rd, 32'h32);
        bus_write(4'd3, 32'h2);
        bus_read(4'd3, rd);
        check("done w1c", rd, 32'h30);

        // Stop during HOLD of index 1
        bus_write(4'd1, 32'd10);
        wq_data.delete();
        wq_cyc.delete();
        bus_write(4'd0, 32'h1);
        wait_writes(2, 40, "stop");
        repeat (3) @(negedge clk);
        bus_write(4'd0, 32'h0);
        bus_read(4'd3, rd);
        check("stop status", rd, 32'h10);
        repeat (40) @(negedge clk);
        check("stop no more writes", 32'(wq_data.size()), 32'd2);
        check("stop pattern held", m_writedata, 32'h02);
        check("stop chipselect", 32'(m_chipselect), 32'd0);

        // Reset in the middle of a run
        wq_data.delete();
        wq_cyc.delete();
        bus_write(4'd0, 32'h1);
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n = wq_data.size();
        check("mid reset m_chipselect", 32'(m_chipselect), 32'd0);
        check("mid reset m_write_n", 32'(m_write_n), 32'd1);
        check("mid reset m_writedata", m_writedata, 32'h0);
        bus_read(4'd3, rd);
        check("mid reset status", rd, 32'h0);
        bus_read(4'd0, rd);
        check("mid reset ctrl", rd, 32'h0);
        bus_read(4'd8, rd);
        check("mid reset table", rd, 32'h0);
        repeat (30) @(negedge clk);
        check("mid reset no writes", 32'(wq_data.size()), 32'(n));

        // LAST lowered below the running index: run wraps through DEPTH-1 first
        exp_tbl = '{6'h05, 6'h0A, 6'h14, 6'h28, 6'h11, 6'h22, 6'h33, 6'h3C};
        load_table();
        bus_write(4'd2, 32'd3);
        bus_write(4'd1, 32'd4);
        wq_data.delete();
        wq_cyc.delete();
        bus_write(4'd0, 32'h1);
        wait_writes(3, 40, "lower last");
        bus_write(4'd2, 32'd1);
        wait_idle(100, "lower last");
        check("lower last count", 32'(wq_data.size()), 32'd10);
        for (int k = 0; k < 10 && k < wq_data.size(); k++)
            check($sformatf("lower last data[%0d]", k), wq_data[k], 32'(exp_tbl[k % DEPTH]));
        bus_read(4'd3, rd);
        check("lower last status", rd, 32'h12);
        bus_write(4'd3, 32'h2);

`ifdef PIO_SEQ_IRQ_EN
        // Done interrupt: rises one cycle after DONE, falls one cycle after the clear
        begin
            logic seen;
            seen = 1'b0;
            bus_write(4'd2, 32'd0);
            bus_write(4'd1, 32'd5);
            bus_write(4'd0, 32'h5);
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                bus_read(4'd3, rd);
                if (rd[1]) seen = 1'b1;
            end
            check("irq done seen", 32'(seen), 32'd1);
            check("irq low with done", 32'(irq), 32'd0);
            @(negedge clk);
            check("irq high next cycle", 32'(irq), 32'd1);
            bus_write(4'd3, 32'h2);
            check("irq still high at clear", 32'(irq), 32'd1);
            @(negedge clk);
            check("irq low after clear", 32'(irq), 32'd0);
            bus_write(4'd0, 32'h0);
        end
`endif

        // Randomized runs against the schedule model
        for (int r = 0; r < 6; r++) begin
            int last, period;
            for (int i = 0; i < DEPTH; i++) exp_tbl[i] = DW'($urandom());
            load_table();
            last   = $urandom_range(0, DEPTH - 1);
            period = $urandom_range(0, 12);
            run_once(last, period, $sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
